ledport_arb_fta64: RTL
======================

Name: ledport_arb_fta64

Overview:
- Round-robin arbiter sharing one fta64 slave port between NREQ request masters. Typical slave is the LED port; the block works with any single-cycle or multi-cycle fta64 slave.
- Grants one requester at a time and drives the slave's select and request.
- Routes the slave response back to the granted requester as a registered one-cycle pulse.
- A watchdog returns an error response if the slave never acknowledges.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, cycles in ISSUE without slave ack before an error response is forced (1..65535).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cs_i  input  NREQ  per-requester select; held high until that requester receives ack or err.
- req_i  input  NREQ x fta_cmd_request64_t  per-requester request.
- resp_o  output  NREQ x fta_cmd_response64_t  per-requester response.
- cs_o  output  1  slave select.
- req_o  output  fta_cmd_request64_t  request to slave.
- resp_i  input  fta_cmd_response64_t  response from slave.
- busy  output  1  high in any state other than IDLE.
- gnt  output  $clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, cs_o=0, req_o=all zero, busy=0, gnt=NREQ-1, watchdog=0.
  - All resp_o[i] all zero, with ack=0 and err=0.
  - rst asserted mid-transaction aborts it: no response is delivered, and a pending requester re-arbitrates after reset.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any cs_i is high, select the first high bit searching gnt+1, gnt+2, … modulo NREQ.
  - Latch that index into gnt and latch req_i[index] into req_o. Move to ISSUE on the next edge.
  - With no request pending, remain in IDLE with cs_o=0.
- ISSUE:
  - cs_o=1. req_o is held stable from the latch and ignores further req_i changes.
  - The watchdog increments each cycle.
  - On resp_i.ack=1 or resp_i.err=1, register the response into resp_o[gnt]:
    - all fields copied from resp_i;
    - cid and tid taken from the latched req_o.
  - Then drop cs_o, clear the watchdog and go to RESP.
  - If the watchdog reaches TIMEOUT with no ack, register resp_o[gnt] as follows and go to RESP:
    - err=1, ack=0, rty=0, dat=0;
    - adr=req_o.padr, cid and tid from req_o, pri=4'd7.
- RESP:
  - resp_o[gnt] ack/err is high for exactly this one cycle.
  - Next edge: clear all resp_o ack and err, and go to IDLE.
  - The granted requester must drop cs_i in the cycle it sees the response. The arbiter does not sample cs_i in RESP.
- Latency:
  - cs_i rises at edge 0, so cs_o is high from edge 1.
  - A zero-wait slave acks in that same cycle, so resp_o ack is high from edge 2.
  - The arbiter is back in IDLE at edge 3. Back-to-back throughput is one transaction per 3 cycles.
- Fairness:
  - After a grant to index k, k has the lowest priority at the next arbitration.
  - With all NREQ requesters continuously pending, grants rotate 0,1,2,…,NREQ-1,0 after reset.
- Isolation:
  - resp_o[j] for j≠gnt stays all zero at all times.
  - Slave ack while in IDLE or RESP is ignored.
  - Simultaneous ack and watchdog expiry: ack wins and a normal response is delivered.
- Requester dropping cs_i while granted: the transaction still completes and the response is still pulsed. This is not a protocol abort.
- Arithmetic:
  - Pointer wraps modulo NREQ; for non-power-of-two NREQ, gnt+1 = NREQ wraps to 0.
  - Watchdog is $clog2(TIMEOUT+1) bits and never wraps, because it is cleared on leaving ISSUE.

Test Plan:
- Single requester, zero-wait slave:
  - Stimulus: NREQ=4; after reset cs_i=4'b0100, req_i[2].dat=64'h5A, tid=3; slave acks combinationally.
  - Required: cs_o high at edge 1 with req_o.dat=5A; resp_o[2].ack=1 with tid=3 at edge 2 only; busy low at edge 3; gnt=2.
- All requesting:
  - Stimulus: cs_i=4'b1111 held, each requester re-asserting immediately after its ack.
  - Required: grant order 0,1,2,3,0; each resp_o pulse separated by 3 cycles.
- Priority rotation:
  - Stimulus: after gnt=1, cs_i=4'b0011.
  - Required: requester 0 is granted next, not 1.
- Timeout:
  - Stimulus: TIMEOUT=8, slave never acks, cs_i[1]=1.
  - Required: cs_o high for 8 cycles; resp_o[1].err=1, ack=0, for one cycle; resp_o[0], [2] and [3] remain zero.
- Wait-state slave:
  - Stimulus: ack delayed 3 cycles; req_i[0] changes during ISSUE.
  - Required: req_o unchanged until ack; resp_o[0].ack pulses one cycle after slave ack.
- Reset mid-ISSUE:
  - Stimulus: rst high for 1 cycle while cs_o=1.
  - Required: the next cycle has cs_o=0, no resp_o ack, gnt=3 and state IDLE; the still-pending requester is re-granted afterwards.

Source files
------------

// File: rtl/ledport_arb_fta64.sv
// fta64 command bundles plus a round-robin arbiter that shares one
// fta64 slave port between NREQ masters, with a no-ack watchdog.
package fta64_pkg;

    typedef struct packed {
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [4:0]  cmd;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] padr;
        logic [63:0] dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [3:0]  pri;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_response64_t;

endpackage

module ledport_arb_fta64
    import fta64_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            cs_i,
    input  fta_cmd_request64_t         req_i  [NREQ],
    output fta_cmd_response64_t        resp_o [NREQ],
    output logic                       cs_o,
    output fta_cmd_request64_t         req_o,
    input  fta_cmd_response64_t        resp_i,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    gnt
);

    localparam int GW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    fta_cmd_request64_t  req_q, req_d;
    fta_cmd_response64_t resp_q, resp_d;
    logic [WW-1:0]       wd_q, wd_d;

    logic                found;
    logic [GW-1:0]       pick;
    int                  idx;

    // Search starts just after the last grant, so it gets lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = gnt_q;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(gnt_q) + i) % NREQ;
            if (!found && cs_i[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        resp_d  = resp_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                resp_d = '0;
                if (found) begin
                    gnt_d   = pick;
                    req_d   = req_i[pick];
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A real ack beats a watchdog expiry in the same cycle.
                if (resp_i.ack || resp_i.err) begin
                    resp_d     = resp_i;
                    resp_d.cid = req_q.cid;
                    resp_d.tid = req_q.tid;
                    wd_d       = '0;
                    state_d    = RESP;
                end else if (wd_q == WD_LAST) begin
                    resp_d     = '0;
                    resp_d.err = 1'b1;
                    resp_d.adr = req_q.padr;
                    resp_d.cid = req_q.cid;
                    resp_d.tid = req_q.tid;
                    resp_d.pri = 4'd7;
                    wd_d       = '0;
                    state_d    = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                resp_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GW'(NREQ - 1);
            req_q   <= '0;
            resp_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            resp_o[i] = '0;
            if (state_q == RESP && gnt_q == GW'(i)) begin
                resp_o[i] = resp_q;
            end
        end
    end

    assign cs_o  = (state_q == ISSUE);
    assign req_o = req_q;
    assign busy  = (state_q != IDLE);
    assign gnt   = gnt_q;

endmodule
